// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: configurable UART transmitter (width, parity, stop bits, bit order, baud)
// fed by a small write FIFO; bit timing comes from an internal divider on clk_i.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int BAUD_DIV   = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              wr_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o,
    output logic              busy_o,
    output logic              TxD_o
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int IW = $clog2(DATA_W + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_W - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              full_q, empty_q, ovf_q;
    logic              push, load;

    // A full FIFO never accepts, even when a pop happens on the same edge.
    assign push  = wr_i && !full_q;
    assign cnt_d = cnt_q + CW'(push) - CW'(load);

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_q + AW'(push);
            rptr_q  <= rptr_q + AW'(load);
            cnt_q   <= cnt_d;
            full_q  <= cnt_d == FULL_CNT;
            empty_q <= cnt_d == '0;
            ovf_q   <= wr_i && full_q;
        end
    end

    state_t            state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              stop_q, stop_d;
    logic [DATA_W-1:0] sh_q, sh_d, head;
    logic              par_q, par_d, txd_q, txd_d, wrap;

    assign head = mem_q[rptr_q];
    assign wrap = baud_q == BAUD_LAST;

    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == S_IDLE || wrap) ? '0 : baud_q + 1'b1;
        idx_d   = idx_q;
        stop_d  = stop_q;
        sh_d    = sh_q;
        par_d   = par_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE:  load = !empty_q;
            S_START: if (wrap) begin
                state_d = S_DATA;
                idx_d   = '0;
            end
            S_DATA: if (wrap) begin
                sh_d  = (MSB_FIRST != 0) ? sh_q << 1 : sh_q >> 1;
                idx_d = idx_q + 1'b1;
                if (idx_q == BIT_LAST) begin
                    state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    stop_d  = 1'b0;
                end
            end
            S_PAR: if (wrap) begin
                state_d = S_STOP;
                stop_d  = 1'b0;
            end
            S_STOP: if (wrap) begin
                stop_d = 1'b1;
                if (stop_q == STOP_LAST) begin
                    state_d = S_IDLE;
                    load    = !empty_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Popping overrides the IDLE transition so back-to-back frames have no gap.
        if (load) begin
            state_d = S_START;
            sh_d    = head;
            par_d   = ^head ^ ODD;
            baud_d  = '0;
        end
        txd_d = state_d == S_START ? 1'b0 :
                state_d == S_DATA  ? ((MSB_FIRST != 0) ? sh_d[DATA_W-1] : sh_d[0]) :
                state_d == S_PAR   ? par_d : 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign overflow_o = ovf_q;
    assign busy_o     = state_q != S_IDLE;
    assign TxD_o      = txd_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three uart_tx_fifo configurations checked against a bit-slot scoreboard.
module tb_uart_tx_fifo;
    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] d0 = '0, d2 = '0;
    logic [6:0] d1 = '0;
    logic [2:0] wr = '0;
    logic [2:0] full, empty, ovf, busy, txd;
    logic       exp_q[$];
    int         checks = 0, fails = 0;
    int         dw_c[3]  = '{8, 7, 8};
    int         par_c[3] = '{0, 1, 2};
    int         sb_c[3]  = '{1, 2, 1};
    int         msb_c[3] = '{0, 0, 1};

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_W(8), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0), .FIFO_DEPTH(4)) u0 (
        .clk_i(clk), .rst_i(rst), .data_i(d0), .wr_i(wr[0]), .full_o(full[0]), .empty_o(empty[0]),
        .overflow_o(ovf[0]), .busy_o(busy[0]), .TxD_o(txd[0]));
    uart_tx_fifo #(.DATA_W(7), .BAUD_DIV(4), .PARITY(1), .STOP_BITS(2), .MSB_FIRST(0), .FIFO_DEPTH(4)) u1 (
        .clk_i(clk), .rst_i(rst), .data_i(d1), .wr_i(wr[1]), .full_o(full[1]), .empty_o(empty[1]),
        .overflow_o(ovf[1]), .busy_o(busy[1]), .TxD_o(txd[1]));
    uart_tx_fifo #(.DATA_W(8), .BAUD_DIV(4), .PARITY(2), .STOP_BITS(1), .MSB_FIRST(1), .FIFO_DEPTH(4)) u2 (
        .clk_i(clk), .rst_i(rst), .data_i(d2), .wr_i(wr[2]), .full_o(full[2]), .empty_o(empty[2]),
        .overflow_o(ovf[2]), .busy_o(busy[2]), .TxD_o(txd[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for every bit slot of one frame.
    function automatic void push_frame(input int k, input logic [8:0] w);
        logic p = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < dw_c[k]; i++) begin
            exp_q.push_back(msb_c[k] != 0 ? w[dw_c[k]-1-i] : w[i]);
            p ^= w[i];
        end
        if (par_c[k] != 0) exp_q.push_back(p ^ (par_c[k] == 2));
        for (int i = 0; i < sb_c[k]; i++) exp_q.push_back(1'b1);
    endfunction

    task automatic wr_word(input int k, input logic [8:0] w);
        if (k == 0) d0 = w[7:0];
        else if (k == 1) d1 = w[6:0];
        else d2 = w[7:0];
        wr[k] = 1'b1;
        @(negedge clk);
        wr[k] = 1'b0;
    endtask

    // Finds the start bit, then samples mid-slot every 4 cycles without resyncing,
    // so back-to-back frames must be gapless and exactly timed.
    task automatic run_frames(input int k);
        int n = 0;
        while (txd[k] !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("start_timeout", 32'(txd[k]), 0);
            exp_q.delete();
            return;
        end
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            chk("txd_slot", 32'(txd[k]), 32'(exp_q.pop_front()));
            chk("busy_in_frame", 32'(busy[k]), 1);
            if (exp_q.size() > 0) repeat (4) @(negedge clk);
        end
        @(negedge clk);
        chk("busy_last_cycle", 32'(busy[k]), 1);
        @(negedge clk);
        chk("busy_fall", 32'(busy[k]), 0);
        chk("txd_idle", 32'(txd[k]), 1);
    endtask

    initial begin
        logic bad;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 3'b111);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 3'b111);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        @(negedge clk);

        push_frame(0, 9'h0A5);
        wr_word(0, 9'h0A5);
        chk("lat_empty_fall", 32'(empty[0]), 0);
        chk("lat_busy_low", 32'(busy[0]), 0);
        chk("lat_txd_high", 32'(txd[0]), 1);
        @(negedge clk);
        chk("lat_txd_fall", 32'(txd[0]), 0);
        chk("lat_busy_rise", 32'(busy[0]), 1);
        chk("lat_empty_again", 32'(empty[0]), 1);
        run_frames(0);

        push_frame(1, 9'h007);
        wr_word(1, 9'h007);
        run_frames(1);

        push_frame(2, 9'h080);
        wr_word(2, 9'h080);
        run_frames(2);

        for (int i = 0; i < 5; i++) push_frame(0, 9'(8'h31 + 8'(i * 17)));
        fork
            run_frames(0);
            begin
                for (int i = 0; i < 6; i++) wr_word(0, 9'(8'h31 + 8'(i * 17)));
                chk("b2b_ovf_pulse", 32'(ovf[0]), 1);
                chk("b2b_full", 32'(full[0]), 1);
                chk("b2b_not_empty", 32'(empty[0]), 0);
                repeat (35) @(negedge clk);
                chk("pp_ovf_low", 32'(ovf[0]), 0);
                chk("pp_full_before", 32'(full[0]), 1);
                wr_word(0, 9'h0EE);
                chk("pp_ovf_pulse", 32'(ovf[0]), 1);
            end
        join
        chk("b2b_drained", 32'(empty[0]), 1);

        wr_word(0, 9'h0F7);
        wr_word(0, 9'h011);
        wr_word(0, 9'h022);
        repeat (16) @(negedge clk);
        chk("mid_bit3", 32'(txd[0]), 0);
        chk("mid_busy", 32'(busy[0]), 1);
        chk("mid_queued", 32'(empty[0]), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_txd", 32'(txd[0]), 1);
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_empty", 32'(empty[0]), 1);
        chk("abort_full", 32'(full[0]), 0);
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad = 1'b1;
        end
        chk("no_tx_after_rst", 32'(bad), 0);

        push_frame(0, 9'h05A);
        wr_word(0, 9'h05A);
        run_frames(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end
endmodule
